// File: rtl/ehgu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ehgu_pkg
// Brief    : Shared state encoding and pointer helper for the delay-line ctrl.
// Revision : 1.0
// ============================================================================
package ehgu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } ehgu_dl_state_e;

    // Operates on a fixed 16-bit carrier so callers of any width up to 16 can share it.
    function automatic logic [15:0] mod_inc(input logic [15:0] val, input logic [15:0] modulus);
        return (val >= (modulus - 16'd1)) ? 16'd0 : (val + 16'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ehgu_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : ehgu_mod_counter
// Brief    : Modulo-MOD address pointer with synchronous clear and increment.
// Revision : 1.0
// ============================================================================
module ehgu_mod_counter
    import ehgu_pkg::*;
#(
    parameter int MOD    = 128,
    parameter int AWIDTH = 8
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [AWIDTH-1:0] count
);

    logic [AWIDTH-1:0] r_count;

    always_ff @(posedge wclk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= AWIDTH'(mod_inc(16'(r_count), 16'(MOD)));
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ehgu_delay_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ehgu_delay_line_ctrl
// Brief    : Sequencer for a circular-buffer delay line on a 1-cycle-latency SDP RAM.
// Revision : 1.0
// ============================================================================
module ehgu_delay_line_ctrl
    import ehgu_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int DEPTH  = 128
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [AWIDTH-1:0] cfg_delay,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic              mem_re,
    output logic [AWIDTH-1:0] mem_raddr,
    output logic              out_valid,
    output logic [AWIDTH:0]   occupancy,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [AWIDTH:0] c_DEPTH = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] c_ONE   = (AWIDTH+1)'(1);

    ehgu_dl_state_e    r_state;
    ehgu_dl_state_e    w_state_nxt;
    logic [AWIDTH-1:0] r_delay;
    logic [AWIDTH:0]   r_occ;
    logic [AWIDTH:0]   w_occ_nxt;
    logic              r_out_valid;
    logic              r_done;
    logic              r_cfg_err;
    logic              w_done_nxt;
    logic              w_cfg_ok;
    logic              w_start_ok;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_re;
    logic [AWIDTH-1:0] w_wptr;
    logic [AWIDTH-1:0] w_rptr;

    assign w_cfg_ok   = (cfg_delay != '0) && ({1'b0, cfg_delay} < c_DEPTH);
    assign w_start_ok = (r_state == IDLE) && start && w_cfg_ok;
    assign w_in_ready = (r_state == FILL) || (r_state == RUN);
    assign w_accept   = in_valid && w_in_ready;
    // In RUN a read is paired with every write so the delay is measured in samples.
    assign w_re       = ((r_state == RUN) && w_accept) ||
                        ((r_state == FLUSH) && (r_occ != '0));

    always_comb begin
        w_state_nxt = r_state;
        w_occ_nxt   = r_occ;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = FILL;
                    w_occ_nxt   = '0;
                end
            end
            FILL, RUN: begin
                if ((r_state == FILL) && w_accept) begin
                    w_occ_nxt = r_occ + c_ONE;
                end
                if (stop) begin
                    if (w_occ_nxt == '0) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = FLUSH;
                    end
                end else if ((r_state == FILL) && w_accept && (w_occ_nxt == {1'b0, r_delay})) begin
                    w_state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (r_occ != '0) begin
                    w_occ_nxt = r_occ - c_ONE;
                end
                if (r_occ <= c_ONE) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_occ       <= '0;
            r_delay     <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_occ       <= w_occ_nxt;
            r_out_valid <= w_re;
            r_done      <= w_done_nxt;
            r_cfg_err   <= (r_state == IDLE) && start && !w_cfg_ok;
            if (w_start_ok) begin
                r_delay <= cfg_delay;
            end
        end
    end

    ehgu_mod_counter #(
        .MOD    (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_wptr (
        .wclk  (wclk),
        .rst   (rst),
        .clear (w_start_ok),
        .inc   (w_accept),
        .count (w_wptr)
    );

    ehgu_mod_counter #(
        .MOD    (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_rptr (
        .wclk  (wclk),
        .rst   (rst),
        .clear (w_start_ok),
        .inc   (w_re),
        .count (w_rptr)
    );

    assign in_ready  = w_in_ready;
    assign mem_we    = w_accept;
    assign mem_waddr = w_wptr;
    assign mem_re    = w_re;
    assign mem_raddr = w_rptr;
    assign out_valid = r_out_valid;
    assign occupancy = r_occ;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: doc/ehgu_delay_line_ctrl.md
Name: ehgu_delay_line_ctrl

Overview:
- Controller that sequences a DEPTH-entry circular-buffer delay line built on an external simple dual-port memory with 1-cycle read latency.
- Takes a run-time programmable delay and fills the buffer to that depth, then streams with a constant delay.
- On stop, drains the remaining samples, then returns to idle.
- Sits between the sample source and the delay-line memory; owns all memory write/read enables and addresses.

Parameters:
- AWIDTH, 8, address width; DEPTH must be <= 2**AWIDTH.
- DEPTH, 128, number of buffer entries; addresses wrap modulo DEPTH.

Ports:
- wclk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  one-cycle pulse; begins a session with cfg_delay.
- stop  input  1  one-cycle pulse; ends the session and drains the buffer.
- cfg_delay  input  AWIDTH  requested delay in samples; legal range 1..DEPTH-1.
- in_valid  input  1  source presents a sample this cycle.
- in_ready  output  1  controller accepts a sample this cycle.
- mem_we  output  1  memory write enable.
- mem_waddr  output  AWIDTH  memory write address.
- mem_re  output  1  memory read enable.
- mem_raddr  output  AWIDTH  memory read address.
- out_valid  output  1  memory read data valid; mem_re delayed 1 cycle.
- occupancy  output  AWIDTH+1  samples currently held.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when the drain completes.
- cfg_err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, waddr=0, raddr=0, occupancy=0, delay register=0.
  - All output strobes 0, including out_valid.
  - This also applies mid-session; no drain is performed.
- Accept condition: accept = in_valid & in_ready. mem_we = accept; mem_waddr = write pointer.
- Pointer wrap: pointers increment modulo DEPTH; DEPTH-1 wraps to 0.
- Outputs: in_ready is combinational from state. mem_we, mem_re and addresses are combinational from state, pointers and in_valid. out_valid, done and cfg_err are registered.
- IDLE:
  - in_ready=0.
  - start=1 with 1 <= cfg_delay <= DEPTH-1: latch delay, clear pointers and occupancy, go to FILL.
  - start=1 with cfg_delay outside that range (0 or >= DEPTH): cfg_err=1 next cycle, stay in IDLE.
  - stop is ignored.
- FILL:
  - in_ready=1; no reads.
  - Each accept increments waddr and occupancy.
  - The accept that makes occupancy equal delay moves the state to RUN on the next cycle.
- RUN:
  - in_ready=1.
  - Each accept also sets mem_re=1, mem_raddr=raddr, and increments raddr.
  - occupancy stays equal to delay.
  - No accept means no read; the delay is counted in samples, not cycles.
  - mem_raddr == (mem_waddr - delay) mod DEPTH always, so the read and write addresses never collide.
- Stop handling (FILL or RUN):
  - A sample accepted in the stop cycle is still written, and read too if in RUN.
  - Next state is FLUSH; occupancy == 0 goes straight to IDLE with done pulsed.
- FLUSH:
  - in_ready=0.
  - mem_re=1 every cycle while occupancy > 0; raddr increments, occupancy decrements.
  - The cycle occupancy reaches 0 moves the state to IDLE, with done=1 on the following cycle.
- Ignored inputs: start while busy is ignored; stop in FLUSH is ignored.
- Simultaneous start and stop in IDLE: start wins; stop is ignored.
- Invariants: occupancy <= delay <= DEPTH-1 always. out_valid count equals read count.

Decomposition:
- Package ehgu_pkg:
  - state enum ehgu_dl_state_e {IDLE, FILL, RUN, FLUSH}, 2 bits.
  - Helper function for modulo-DEPTH increment.
- Sub-module ehgu_mod_counter:
  - Ports: clear, inc; parameters MOD and AWIDTH.
  - Instantiated twice, for the write and read pointers.

Test Plan:
- Reset, start, cfg_delay=4, in_valid continuous: in_ready=1 from the cycle after start. First mem_re on the 5th accept with mem_raddr=0, mem_waddr=4. out_valid one cycle later. occupancy holds at 4.
- RUN with in_valid toggling 1010: mem_re only on accept cycles. mem_raddr == (mem_waddr-4) mod 128. occupancy constant at 4.
- DEPTH=128, cfg_delay=127, stream 300 samples: both pointers wrap 127->0 with no collision. Read data equals write data from 127 accepts earlier.
- stop in RUN with delay 4: exactly 4 FLUSH reads on consecutive cycles, occupancy 4->0, then IDLE. done pulses once; in_ready=0 throughout FLUSH.
- start with cfg_delay=0, then again with cfg_delay=128 (AWIDTH=8): cfg_err pulses each time; state stays IDLE; no mem_we.
- rst asserted mid-FILL at occupancy=2: next cycle all outputs reset and busy=0. A following start, cfg_delay=2, behaves as from cold reset.
